imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_ctrl.sv | 132 +++++++++++++
 tb/tb_imem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ctrl.sv
// Instruction memory with a 1-cycle fetch port and a DMA burst-load engine.
// Issue sees imem_dma_pif one cycle before write beats start (ARM), so it can stall cleanly.
module imem_ctrl #(
   parameter int unsigned AW = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic        fetch_en,
   output logic [31:0] id_inst,
   output logic        imem_dma_pif,
   input  logic        dma_start,
   input  logic [31:0] dma_base,
   input  logic [15:0] dma_len,
   input  logic        dma_wvalid,
   input  logic [31:0] dma_wdata,
   output logic        dma_wready,
   output logic        dma_busy,
   output logic        dma_done,
   output logic        dma_err
);

   localparam int unsigned DEPTH   = 1 << AW;
   localparam logic [31:0] NOP_INS = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, ARM, BURST, DONE} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [15:0]   rem_q, rem_d;
   logic [31:0]   inst_q, inst_d;
   logic          pif_q, pif_d;
   logic          wready_q, wready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          mem_we_c;
   logic [AW-1:0] fetch_idx_c;
   logic [31:0]   mem_q [DEPTH];
   logic          unused_c;

   assign fetch_idx_c = pc[AW+1:2];
   assign unused_c    = ^{pc[31:AW+2], pc[1:0], dma_base[31:AW+2]};

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      rem_d    = rem_q;
      inst_d   = inst_q;
      err_d    = 1'b0;
      mem_we_c = 1'b0;

      if (fetch_en && (state_q == IDLE || state_q == DONE)) begin
         inst_d = mem_q[fetch_idx_c];
      end

      unique case (state_q)
         IDLE: begin
            if (dma_start) begin
               if (dma_base[1:0] != 2'b00) begin
                  err_d = 1'b1;
               end else if (dma_len == 16'd0) begin
                  state_d = DONE;
               end else begin
                  idx_d   = dma_base[AW+1:2];
                  rem_d   = dma_len;
                  state_d = ARM;
               end
            end
         end
         ARM: state_d = BURST;
         BURST: begin
            if (dma_wvalid && wready_q) begin
               mem_we_c = 1'b1;
               idx_d    = idx_q + AW'(1);
               rem_d    = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it
      pif_d    = (state_d == ARM) || (state_d == BURST);
      wready_d = (state_d == BURST);
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         rem_q    <= '0;
         inst_q   <= NOP_INS;
         pif_q    <= 1'b0;
         wready_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rem_q    <= rem_d;
         inst_q   <= inst_d;
         pif_q    <= pif_d;
         wready_q <= wready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Storage is deliberately not reset; a reset mid-burst keeps written words
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_q[idx_q] <= dma_wdata;
      end
   end

   assign id_inst      = inst_q;
   assign imem_dma_pif = pif_q;
   assign dma_wready   = wready_q;
   assign dma_busy     = busy_q;
   assign dma_done     = done_q;
   assign dma_err      = err_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl (AW=4): directed corner sequences, a fetch
// vector table and randomized bursts checked against a transaction-level model.
module tb_imem_ctrl;

   localparam int unsigned AW  = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic        fetch_en;
   logic [31:0] id_inst;
   logic        imem_dma_pif;
   logic        dma_start;
   logic [31:0] dma_base;
   logic [15:0] dma_len;
   logic        dma_wvalid;
   logic [31:0] dma_wdata;
   logic        dma_wready;
   logic        dma_busy;
   logic        dma_done;
   logic        dma_err;

   int          checks;
   int          errors;
   logic [31:0] mdl [16];
   logic [31:0] exp_inst;

   typedef struct {
      logic [31:0] pc;
      logic        en;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [6];

   imem_ctrl #(.AW(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc           (pc),
      .fetch_en     (fetch_en),
      .id_inst      (id_inst),
      .imem_dma_pif (imem_dma_pif),
      .dma_start    (dma_start),
      .dma_base     (dma_base),
      .dma_len      (dma_len),
      .dma_wvalid   (dma_wvalid),
      .dma_wdata    (dma_wdata),
      .dma_wready   (dma_wready),
      .dma_busy     (dma_busy),
      .dma_done     (dma_done),
      .dma_err      (dma_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%b exp=%b", nm, act, exp);
      end
   endtask

   task automatic fetch_chk(input logic [31:0] a, input logic en);
      fetch_en = en;
      pc       = a;
      step();
      fetch_en = 1'b0;
      if (en) exp_inst = mdl[a[5:2]];
      chk("fetch", id_inst, exp_inst);
      chk1("idle_busy", dma_busy, 1'b0);
   endtask

   // One complete DMA transaction from IDLE, with per-cycle protocol checks
   task automatic burst(input logic [31:0] base, input int len, input int gap,
                        input bit fd, input bit sd, input bit rnd, input logic [31:0] d0);
      logic [3:0] idx;
      int         beats;
      int         cyc;
      logic       v;
      dma_start  = 1'b1;
      dma_base   = base;
      dma_len    = 16'(len);
      fetch_en   = 1'b0;
      dma_wvalid = 1'b0;
      step();
      dma_start = 1'b0;
      if (base[1:0] != 2'b00) begin
         chk1("err_pulse", dma_err, 1'b1);
         chk1("err_busy", dma_busy, 1'b0);
         chk1("err_pif", imem_dma_pif, 1'b0);
         step();
         chk1("err_clr", dma_err, 1'b0);
         chk1("err_idle", dma_busy, 1'b0);
         chk1("err_nopif", imem_dma_pif, 1'b0);
         return;
      end
      chk1("no_err", dma_err, 1'b0);
      if (len != 0) begin
         chk1("arm_pif", imem_dma_pif, 1'b1);
         chk1("arm_wready", dma_wready, 1'b0);
         chk1("arm_busy", dma_busy, 1'b1);
         dma_wvalid = 1'($urandom_range(1));
         dma_wdata  = $urandom;
         fetch_en   = fd;
         pc         = $urandom;
         dma_start  = sd;
         step();
         idx   = base[5:2];
         beats = 0;
         cyc   = 0;
         while (beats < len && cyc < 4000) begin
            chk1("burst_pif", imem_dma_pif, 1'b1);
            chk1("burst_wready", dma_wready, 1'b1);
            chk1("burst_done", dma_done, 1'b0);
            chk("burst_hold", id_inst, exp_inst);
            v = (gap < 0) ? ($urandom_range(2) != 0) : ((cyc % (gap + 1)) == 0);
            dma_wvalid = v;
            dma_wdata  = (v && !rnd) ? d0 + 32'(beats) : $urandom;
            pc         = $urandom;
            dma_start  = sd && ($urandom_range(1) == 1);
            dma_base   = $urandom;
            dma_len    = 16'($urandom);
            if (v) begin
               mdl[idx] = dma_wdata;
               idx++;
               beats++;
            end
            step();
            cyc++;
         end
         if (beats < len) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout act=%0d exp=%0d", beats, len);
         end
      end
      dma_wvalid = 1'b0;
      dma_start  = 1'b0;
      chk1("done_pulse", dma_done, 1'b1);
      chk1("done_pif", imem_dma_pif, 1'b0);
      chk1("done_wready", dma_wready, 1'b0);
      chk1("done_busy", dma_busy, 1'b1);
      chk("done_hold", id_inst, exp_inst);
      fetch_en = 1'b1;
      pc       = $urandom;
      step();
      fetch_en = 1'b0;
      exp_inst = mdl[pc[5:2]];
      chk1("done_clr", dma_done, 1'b0);
      chk1("idle_busy", dma_busy, 1'b0);
      chk1("idle_pif", imem_dma_pif, 1'b0);
      chk("done_fetch", id_inst, exp_inst);
   endtask

   initial begin
      logic [31:0] b;
      int          k;
      checks = 0;
      errors = 0;
      tbl[0] = '{32'h0000_0104, 1'b1, 32'hB};
      tbl[1] = '{32'h0000_0100, 1'b1, 32'hA};
      tbl[2] = '{32'h0000_010B, 1'b1, 32'hC};
      tbl[3] = '{32'hFFFF_FF04, 1'b1, 32'hB};
      tbl[4] = '{32'h0000_0208, 1'b1, 32'hC};
      tbl[5] = '{32'h0000_0004, 1'b0, 32'hC};

      rst_n      = 1'b0;
      pc         = '0;
      fetch_en   = 1'b0;
      dma_start  = 1'b0;
      dma_base   = '0;
      dma_len    = '0;
      dma_wvalid = 1'b0;
      dma_wdata  = '0;
      exp_inst   = NOP;
      #12;
      chk("rst_inst", id_inst, NOP);
      chk1("rst_pif", imem_dma_pif, 1'b0);
      chk1("rst_wready", dma_wready, 1'b0);
      chk1("rst_busy", dma_busy, 1'b0);
      chk1("rst_done", dma_done, 1'b0);
      chk1("rst_err", dma_err, 1'b0);
      rst_n = 1'b1;
      step();

      // Fill every word so later fetches have known contents
      burst(32'h0, 16, -1, 1'b0, 1'b0, 1'b1, 32'h0);

      // Back-to-back 3-beat load, then table of fetches
      burst(32'h100, 3, 0, 1'b0, 1'b0, 1'b0, 32'hA);
      for (int i = 0; i < 6; i++) begin
         fetch_en = tbl[i].en;
         pc       = tbl[i].pc;
         step();
         chk("tbl_fetch", id_inst, tbl[i].exp);
      end
      fetch_en = 1'b0;
      exp_inst = tbl[5].exp;

      // 2 beats separated by a 3-cycle wvalid gap
      burst(32'h14, 2, 3, 1'b0, 1'b0, 1'b0, 32'h55);
      fetch_chk(32'h14, 1'b1);
      chk("gap_w0", id_inst, 32'h55);
      fetch_chk(32'h18, 1'b1);
      chk("gap_w1", id_inst, 32'h56);
      fetch_chk(32'h1C, 1'b1);

      // Misaligned request and zero-length request
      burst(32'h102, 5, 0, 1'b0, 1'b0, 1'b1, 32'h0);
      burst(32'h100, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0);

      // Index wrap at the top of a 16-word memory
      burst(32'h3C, 2, 0, 1'b0, 1'b0, 1'b0, 32'h1);
      fetch_chk(32'h40, 1'b1);
      chk("wrap_lo", id_inst, 32'h2);
      fetch_chk(32'h3C, 1'b1);
      chk("wrap_hi", id_inst, 32'h1);

      // Starts and fetches during a burst must be ignored
      burst(32'h80, 5, -1, 1'b1, 1'b1, 1'b1, 32'h0);

      // Reset after the first of four beats
      dma_start = 1'b1;
      dma_base  = 32'h20;
      dma_len   = 16'd4;
      step();
      dma_start = 1'b0;
      step();
      chk1("rb_wready", dma_wready, 1'b1);
      dma_wvalid = 1'b1;
      dma_wdata  = 32'hD1;
      step();
      dma_wdata = 32'hD2;
      #1 rst_n = 1'b0;
      #1;
      chk("rb_inst", id_inst, NOP);
      chk1("rb_pif", imem_dma_pif, 1'b0);
      chk1("rb_wready0", dma_wready, 1'b0);
      chk1("rb_busy", dma_busy, 1'b0);
      chk1("rb_done", dma_done, 1'b0);
      chk1("rb_err", dma_err, 1'b0);
      dma_wvalid = 1'b0;
      #2 rst_n = 1'b1;
      mdl[8]   = 32'hD1;
      exp_inst = NOP;
      step();
      chk1("rb_nodone", dma_done, 1'b0);
      fetch_chk(32'h20, 1'b1);
      chk("rb_keep", id_inst, 32'hD1);
      burst(32'h20, 4, 0, 1'b0, 1'b0, 1'b0, 32'hE0);
      fetch_chk(32'h2C, 1'b1);
      chk("rb_new", id_inst, 32'hE3);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         k = int'($urandom_range(9));
         b = $urandom;
         if (k == 0) begin
            if (b[1:0] == 2'b00) b[0] = 1'b1;
            burst(b, int'($urandom_range(1, 8)), -1, 1'b0, 1'b0, 1'b1, 32'h0);
         end else begin
            b[1:0] = 2'b00;
            burst(b, (k == 1) ? 0 : int'($urandom_range(1, 24)), -1,
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 32'h0);
         end
         fetch_chk($urandom, 1'($urandom_range(1)));
         fetch_chk($urandom, 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
